// File: rtl/bcd_adder.sv
// ---------------------------------------------------------------------------
// bcd_adder: single-digit BCD adder with registered outputs.
//
// Stage 1 adds the two input digits in binary (Z = A + B, 5 bits).
// If Z > 9 the digit is corrected by adding 6 in stage 2, and a decimal
// carry is raised. S, Cout and C all come straight from flops, so they
// only change at a clock edge (or immediately on reset). Latency is one
// cycle and a new pair can be applied every cycle.
// ---------------------------------------------------------------------------

// One-bit full adder, the building block of both adder stages.
module bcd_full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic w_half_sum;

   assign w_half_sum = i_a ^ i_b;
   assign o_sum      = w_half_sum ^ i_cin;
   assign o_cout     = (i_a & i_b) | (i_cin & w_half_sum);

endmodule : bcd_full_adder

// Four-bit ripple-carry adder built from four full-adder instances.
module bcd_ripple4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   // w_carry[n] is the carry into bit n; w_carry[4] is the carry out.
   logic [4:0] w_carry;

   assign w_carry[0] = i_cin;

   for (genvar g = 0; g < 4; g++) begin : g_bit
      bcd_full_adder u_fa (
         .i_a    (i_a[g]),
         .i_b    (i_b[g]),
         .i_cin  (w_carry[g]),
         .o_sum  (o_sum[g]),
         .o_cout (w_carry[g+1])
      );
   end

   assign o_cout = w_carry[4];

endmodule : bcd_ripple4

// Top level: binary add, decimal correction, output registers.
module bcd_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [0:3] S,
   output logic       Cout,
   output logic       C
);

   // Stage 1 result: Z[3:0] and its carry Z[4].
   logic [3:0] w_z_lo;
   logic       w_z_carry;

   // Decimal-correction flag: true when Z > 9.
   logic       w_k;

   // Correction addend for stage 2: 0110 when correcting, else 0000.
   logic [3:0] w_corr;

   // Stage 2 result and its carry. The carry is not part of the BCD
   // result (the decimal carry is K); it is kept only to close the port.
   logic [3:0] w_sum_bcd;
   logic       w_stage2_carry_unused;

   // Output registers. r_s uses descending numbering internally.
   logic [3:0] r_s;
   logic       r_cout;
   logic       r_c;

   // Stage 1: Z = A + B with carry-in 0.
   bcd_ripple4 u_stage1 (
      .i_a    (A),
      .i_b    (B),
      .i_cin  (1'b0),
      .o_sum  (w_z_lo),
      .o_cout (w_z_carry)
   );

   // Z >= 16 always needs correction; for 8..15 correct only 10..15.
   assign w_k    = w_z_carry | (w_z_lo[3] & (w_z_lo[2] | w_z_lo[1]));
   assign w_corr = {1'b0, w_k, w_k, 1'b0};

   // Stage 2: Z[3:0] + correction, modulo 16.
   bcd_ripple4 u_stage2 (
      .i_a    (w_z_lo),
      .i_b    (w_corr),
      .i_cin  (1'b0),
      .o_sum  (w_sum_bcd),
      .o_cout (w_stage2_carry_unused)
   );

   // Register the corrected digit and both carries every cycle.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; the async reset clears all three output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s    <= 4'b0000;
         r_cout <= 1'b0;
         r_c    <= 1'b0;
      end else begin
         r_s    <= w_sum_bcd;
         r_cout <= w_k;
         r_c    <= w_z_carry;
      end
   end

   // S is numbered [0:3]; a whole-vector assignment maps r_s[3] (the MSB)
   // onto S[0] and r_s[0] (the LSB) onto S[3].
   assign S    = r_s;
   assign Cout = r_cout;
   assign C    = r_c;

endmodule : bcd_adder

// File: tb/tb_bcd_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_adder: directed and exhaustive checks of bcd_adder.
// Each applied pair pushes its expected outputs onto a scoreboard queue;
// the entry is popped and compared one edge later, when the DUT shows it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bcd_adder;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] s;
      logic       cout;
      logic       c;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic [0:3] S;
   logic       Cout;
   logic       C;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   bcd_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .S     (S),
      .Cout  (Cout),
      .C     (C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference: binary sum, decimal flag, corrected digit.
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      int   z;
      z      = int'(a) + int'(b);
      e.a    = a;
      e.b    = b;
      e.c    = (z >= 16);
      e.cout = (z > 9);
      if (z <= 19) e.s = 4'(z % 10);
      else         e.s = 4'(((z % 16) + 6) % 16);
      return e;
   endfunction

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // All three outputs must read zero.
   task automatic check_zero(input string tag);
      logic [3:0] s_val;
      s_val = S;
      check({tag, ".S"},    s_val,         4'b0000);
      check({tag, ".Cout"}, {3'b000, Cout}, 4'b0000);
      check({tag, ".C"},    {3'b000, C},    4'b0000);
   endtask

   // Pop the oldest expectation and compare it with the current outputs.
   task automatic compare_front();
      exp_t       e;
      logic [3:0] s_val;
      string      tag;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
         return;
      end
      e     = sb.pop_front();
      s_val = S;
      tag   = $sformatf("%0d+%0d", e.a, e.b);
      check({tag, ".S"},    s_val,          e.s);
      check({tag, ".Cout"}, {3'b000, Cout}, {3'b000, e.cout});
      check({tag, ".C"},    {3'b000, C},    {3'b000, e.c});
   endtask

   // Apply one pair at the falling edge, check it just after the next rise.
   task automatic drive(input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      A = a;
      B = b;
      sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      compare_front();
   endtask

   initial begin
      logic [3:0] held_s;
      logic       held_cout;
      logic       held_c;

      // Reset held with 9+9 on the inputs: outputs stay cleared.
      rst_n = 1'b0;
      A     = 4'd9;
      B     = 4'd9;
      #1;
      check_zero("reset_async");
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_clocked");

      // Release: first edge loads 9+9 -> 1000, Cout=1, C=1.
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(model(4'd9, 4'd9));
      @(posedge clk);
      #1;
      compare_front();

      // Directed cases.
      drive(4'd4, 4'd5);    // 9, no correction
      drive(4'd0, 4'd0);    // 0
      drive(4'd7, 4'd6);    // 13: correction, no binary carry
      drive(4'd5, 4'd5);    // 10: boundary
      drive(4'd9, 4'd8);    // 17: correction with binary carry
      drive(4'd9, 4'd9);    // 18
      drive(4'd15, 4'd15);  // non-BCD: 30 -> 0100, Cout=1, C=1
      drive(4'd8, 4'd1);    // 9: upper edge of no-correction range

      // Inputs changing between edges must not reach the outputs.
      held_s    = S;
      held_cout = Cout;
      held_c    = C;
      #2;
      A = 4'd3;
      B = 4'd2;
      #1;
      check("mid_cycle.S",    S,              held_s);
      check("mid_cycle.Cout", {3'b000, Cout}, {3'b000, held_cout});
      check("mid_cycle.C",    {3'b000, C},    {3'b000, held_c});

      // Exhaustive back-to-back sweep with an async reset mid-stream.
      for (int i = 0; i < 100; i++) begin
         drive(4'(i / 10), 4'(i % 10));
         if (i == 57) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_zero("reset_midstream");
            sb.delete();
            @(posedge clk);
            #1;
            check_zero("reset_midstream_held");
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bcd_adder

// File: doc/bcd_adder.md
Name: bcd_adder

Overview:
Single-digit BCD adder with registered outputs. It adds two 4-bit BCD digits and produces a corrected BCD sum digit, a decimal carry-out, and the raw binary carry of the uncorrected sum. It is the datapath leaf of the adder/subtractor lab project and can be chained by higher-level digit-serial or multi-digit wrappers.

Parameters:
none (digit width fixed at 4 bits)

Ports:
clk   input   1   system clock, rising-edge active
rst_n input   1   asynchronous active-low reset
A     input   4   addend digit, A[3] = MSB, nominal range 0..9
B     input   4   addend digit, B[3] = MSB, nominal range 0..9
S     output  4   corrected BCD sum digit; declared ascending [0:3], S[0] = MSB, S[3] = LSB
Cout  output  1   decimal carry-out (sum >= 10)
C     output  1   binary carry-out of first-stage (uncorrected) 4-bit add

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n = 0, S = 0000, Cout = 0, C = 0, independent of clk. Deassertion takes effect at the next rising clk edge.
- Combinational core, evaluated every cycle on the current A and B:
  - Z[4:0] = A + B as an unsigned 5-bit value. Stage 1 is a 4-bit ripple adder with carry-in 0, and Z[4] is its carry.
  - K = Z[4] | (Z[3] & (Z[2] | Z[1])). K is the decimal-correction flag, true when Z > 9.
  - Stage 2 computes Z[3:0] + (K ? 0110 : 0000), modulo 16. Its carry is discarded.
- Registers update on every rising clk edge when rst_n = 1:
  - S <= stage-2 result, with S[0] = result MSB.
  - Cout <= K.
  - C <= Z[4].
- Latency: exactly 1 clock. The outputs present the sum of the A and B values sampled at the previous rising edge.
- Throughput: one addition per cycle. There is no handshake and no enable.
- Outputs are glitch-free because they are driven only from flops.
- Non-BCD inputs (A or B > 9) are not flagged. The same formula applies deterministically. Example: A = 15, B = 15 gives Z = 30, so C = 1, Cout = 1, S = 0100.
- Stage 1 and stage 2 are each built from four full-adder instances. Behavioural "+" is acceptable only if the results match bit-exactly.
- Asserting reset mid-stream clears the outputs immediately. The first post-reset edge loads the sum of the inputs present at that edge.
- A and B are sampled only at the clock edge. Input changes between edges have no effect on the outputs.

Test Plan:
- Reset: rst_n = 0 with A = 9, B = 9 applied, then toggle clk → S = 0000, Cout = 0, C = 0. Release rst_n → after 1 edge, S = 1000, Cout = 1, C = 1.
- No correction: A = 4, B = 5 → next cycle S = 1001 (9), Cout = 0, C = 0. Also A = 0, B = 0 → S = 0000, Cout = 0, C = 0.
- Correction without binary carry: A = 7, B = 6 (Z = 13) → S = 0011, Cout = 1, C = 0. Boundary case A = 5, B = 5 → S = 0000, Cout = 1, C = 0.
- Correction with binary carry: A = 9, B = 8 (Z = 17) → S = 0111, Cout = 1, C = 1. A = 9, B = 9 → S = 1000, Cout = 1, C = 1.
- Exhaustive plus pipelining: sweep all 100 valid pairs back-to-back, one per cycle. Each cycle's outputs must equal the previous cycle's pair: decimal (A + B) mod 10 on S, and (A + B >= 10) on Cout.
- Asynchronous reset mid-stream: assert rst_n = 0 between clock edges during the sweep → outputs go to 0 without waiting for clk. Streaming resumes correctly one edge after release.
